// File: rtl/writeback_arbiter.sv
// Writeback arbiter: grants one of AluMisc/Mem/Mult per cycle and registers the
// winning write for the register file and the scoreboard pending-clear port.
module writeback_arbiter #(
  parameter int RR_ENABLE    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        am_wb_valid,
  input  logic [4:0]  am_wb_regdest,
  input  logic [31:0] am_wb_data,
  input  logic        am_wb_writereg,
  output logic        am_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_regdest,
  input  logic [31:0] mem_wb_data,
  input  logic        mem_wb_writereg,
  output logic        mem_wb_ready,
  input  logic        mul_wb_valid,
  input  logic [4:0]  mul_wb_regdest,
  input  logic [31:0] mul_wb_data,
  input  logic        mul_wb_writereg,
  output logic        mul_wb_ready,
  output logic [4:0]  wb_reg_writeaddr,
  output logic [31:0] wb_reg_writedata,
  output logic        wb_reg_enablewrite,
  output logic [4:0]  wb_sb_writeaddr,
  output logic [1:0]  wb_sb_unit,
  output logic        wb_sb_enablewrite,
  output logic        wb_conflict
);

  logic [2:0]       valid_s;
  logic [2:0]       promo_s;
  logic [2:0]       grant_s;
  logic [1:0]       win_s;
  logic             xfer_s;
  logic [4:0]       win_rd_s;
  logic [31:0]      win_data_s;
  logic             win_wr_s;
  logic [1:0]       ptr_q, ptr_d;
  logic [2:0][3:0]  cnt_q, cnt_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       unit_q, unit_d;
  logic             reg_en_q, reg_en_d;
  logic             sb_en_q, sb_en_d;
  logic             conflict_q, conflict_d;

  assign valid_s = {mul_wb_valid, mem_wb_valid, am_wb_valid};

  // One-hot grant of the first requester in the order a, b, c.
  function automatic logic [2:0] prio3(input logic [2:0] v, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    logic [2:0] g;
    g = 3'b000;
    if (v[a]) g[a] = 1'b1;
    else if (v[b]) g[b] = 1'b1;
    else if (v[c]) g[c] = 1'b1;
    else g = 3'b000;
    return g;
  endfunction

  // Winner selection: rotating order in RR mode, MUL>MEM>AM with starvation promotion otherwise.
  always_comb begin
    grant_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      promo_s[i] = valid_s[i] && (cnt_q[i] >= 4'(STARVE_LIMIT));
    end
    if (reset) begin
      grant_s = 3'b000;
    end else if (RR_ENABLE != 0) begin
      case (ptr_q)
        2'd0:    grant_s = prio3(valid_s, 2'd0, 2'd1, 2'd2);
        2'd1:    grant_s = prio3(valid_s, 2'd1, 2'd2, 2'd0);
        2'd2:    grant_s = prio3(valid_s, 2'd2, 2'd0, 2'd1);
        default: grant_s = prio3(valid_s, 2'd0, 2'd1, 2'd2);
      endcase
    end else if (|promo_s) begin
      grant_s = prio3(promo_s, 2'd2, 2'd1, 2'd0);
    end else begin
      grant_s = prio3(valid_s, 2'd2, 2'd1, 2'd0);
    end
  end

  assign am_wb_ready  = grant_s[0];
  assign mem_wb_ready = grant_s[1];
  assign mul_wb_ready = grant_s[2];

  // Route the granted unit's payload.
  always_comb begin
    win_s      = 2'd0;
    xfer_s     = 1'b0;
    win_rd_s   = 5'd0;
    win_data_s = 32'd0;
    win_wr_s   = 1'b0;
    case (grant_s)
      3'b001: begin
        win_s = 2'd0; xfer_s = 1'b1;
        win_rd_s = am_wb_regdest; win_data_s = am_wb_data; win_wr_s = am_wb_writereg;
      end
      3'b010: begin
        win_s = 2'd1; xfer_s = 1'b1;
        win_rd_s = mem_wb_regdest; win_data_s = mem_wb_data; win_wr_s = mem_wb_writereg;
      end
      3'b100: begin
        win_s = 2'd2; xfer_s = 1'b1;
        win_rd_s = mul_wb_regdest; win_data_s = mul_wb_data; win_wr_s = mul_wb_writereg;
      end
      default: begin
        win_s = 2'd0; xfer_s = 1'b0;
      end
    endcase
  end

  // Next state: address/data hold when idle, strobes pulse only for real writes.
  always_comb begin
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unit_d     = unit_q;
    ptr_d      = ptr_q;
    reg_en_d   = xfer_s && win_wr_s && (win_rd_s != 5'd0);
    sb_en_d    = xfer_s && win_wr_s && (win_rd_s != 5'd0);
    conflict_d = (valid_s[0] && valid_s[1]) || (valid_s[0] && valid_s[2]) ||
                 (valid_s[1] && valid_s[2]);
    if (xfer_s) begin
      waddr_d = win_rd_s;
      wdata_d = win_data_s;
      unit_d  = win_s;
      ptr_d   = (win_s == 2'd2) ? 2'd0 : (win_s + 2'd1);
    end else begin
      ptr_d = ptr_q;
    end
    for (int i = 0; i < 3; i++) begin
      if (valid_s[i] && !grant_s[i]) begin
        cnt_d[i] = (cnt_q[i] == 4'd15) ? 4'd15 : (cnt_q[i] + 4'd1);
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      unit_q     <= 2'd0;
      reg_en_q   <= 1'b0;
      sb_en_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      unit_q     <= unit_d;
      reg_en_q   <= reg_en_d;
      sb_en_q    <= sb_en_d;
      conflict_q <= conflict_d;
    end
  end

  assign wb_reg_writeaddr   = waddr_q;
  assign wb_reg_writedata   = wdata_q;
  assign wb_reg_enablewrite = reg_en_q;
  assign wb_sb_writeaddr    = waddr_q;
  assign wb_sb_unit         = unit_q;
  assign wb_sb_enablewrite  = sb_en_q;
  assign wb_conflict        = conflict_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a round-robin and a fixed-priority instance, each
// checked every cycle against a behavioural model of grants and registered writes.
module tb_writeback_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v    [2][3];
  logic [4:0]  rd   [2][3];
  logic [31:0] dt   [2][3];
  logic        wr   [2][3];
  logic        rdy  [2][3];
  logic [4:0]  waddr  [2];
  logic [31:0] wdata  [2];
  logic        wen    [2];
  logic [4:0]  sbaddr [2];
  logic [1:0]  sbunit [2];
  logic        sben   [2];
  logic        conf   [2];

  writeback_arbiter #(.RR_ENABLE(1), .STARVE_LIMIT(LIMIT)) u_rr (
    .clock(clk), .reset(rst),
    .am_wb_valid(v[0][0]), .am_wb_regdest(rd[0][0]), .am_wb_data(dt[0][0]),
    .am_wb_writereg(wr[0][0]), .am_wb_ready(rdy[0][0]),
    .mem_wb_valid(v[0][1]), .mem_wb_regdest(rd[0][1]), .mem_wb_data(dt[0][1]),
    .mem_wb_writereg(wr[0][1]), .mem_wb_ready(rdy[0][1]),
    .mul_wb_valid(v[0][2]), .mul_wb_regdest(rd[0][2]), .mul_wb_data(dt[0][2]),
    .mul_wb_writereg(wr[0][2]), .mul_wb_ready(rdy[0][2]),
    .wb_reg_writeaddr(waddr[0]), .wb_reg_writedata(wdata[0]),
    .wb_reg_enablewrite(wen[0]), .wb_sb_writeaddr(sbaddr[0]),
    .wb_sb_unit(sbunit[0]), .wb_sb_enablewrite(sben[0]), .wb_conflict(conf[0])
  );

  writeback_arbiter #(.RR_ENABLE(0), .STARVE_LIMIT(LIMIT)) u_fx (
    .clock(clk), .reset(rst),
    .am_wb_valid(v[1][0]), .am_wb_regdest(rd[1][0]), .am_wb_data(dt[1][0]),
    .am_wb_writereg(wr[1][0]), .am_wb_ready(rdy[1][0]),
    .mem_wb_valid(v[1][1]), .mem_wb_regdest(rd[1][1]), .mem_wb_data(dt[1][1]),
    .mem_wb_writereg(wr[1][1]), .mem_wb_ready(rdy[1][1]),
    .mul_wb_valid(v[1][2]), .mul_wb_regdest(rd[1][2]), .mul_wb_data(dt[1][2]),
    .mul_wb_writereg(wr[1][2]), .mul_wb_ready(rdy[1][2]),
    .wb_reg_writeaddr(waddr[1]), .wb_reg_writedata(wdata[1]),
    .wb_reg_enablewrite(wen[1]), .wb_sb_writeaddr(sbaddr[1]),
    .wb_sb_unit(sbunit[1]), .wb_sb_enablewrite(sben[1]), .wb_conflict(conf[1])
  );

  // Reference state: RR pointer, per-unit wait counts, expected registered outputs.
  int          ptr_m;
  int          wait_m [3];
  int          w_last [2];
  bit          known;
  logic [4:0]  e_waddr [2];
  logic [31:0] e_wdata [2];
  logic [1:0]  e_unit  [2];
  logic        e_wen   [2];
  logic        e_conf  [2];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  function automatic int pick(input int inst);
    int best;
    best = -1;
    if (rst) return -1;
    if (inst == 0) begin
      for (int k = 0; k < 3; k++) begin
        int u;
        u = (ptr_m + k) % 3;
        if (best < 0 && v[0][u]) best = u;
      end
    end else begin
      for (int u = 2; u >= 0; u--)
        if (best < 0 && v[1][u] && wait_m[u] >= LIMIT) best = u;
      for (int u = 2; u >= 0; u--)
        if (best < 0 && v[1][u]) best = u;
    end
    return best;
  endfunction

  task automatic set_req(input int inst, input int u, input logic vv, input logic [4:0] r,
                         input logic [31:0] d, input logic w);
    v[inst][u] = vv; rd[inst][u] = r; dt[inst][u] = d; wr[inst][u] = w;
  endtask

  task automatic set_both(input int u, input logic vv, input logic [4:0] r,
                          input logic [31:0] d, input logic w);
    set_req(0, u, vv, r, d, w);
    set_req(1, u, vv, r, d, w);
  endtask

  task automatic clear_all();
    for (int u = 0; u < 3; u++) set_both(u, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Check mid-cycle, take the edge, advance the model, optionally draw new requests.
  task automatic step(input bit rnd);
    #4;
    for (int inst = 0; inst < 2; inst++) begin
      w_last[inst] = pick(inst);
      for (int u = 0; u < 3; u++) chk("ready", inst, rdy[inst][u], (w_last[inst] == u));
      if (known) begin
        chk("reg_writeaddr", inst, waddr[inst], e_waddr[inst]);
        chk("reg_writedata", inst, wdata[inst], e_wdata[inst]);
        chk("reg_enablewrite", inst, wen[inst], e_wen[inst]);
        chk("sb_writeaddr", inst, sbaddr[inst], e_waddr[inst]);
        chk("sb_unit", inst, sbunit[inst], e_unit[inst]);
        chk("sb_enablewrite", inst, sben[inst], e_wen[inst]);
        chk("conflict", inst, conf[inst], e_conf[inst]);
      end
    end
    @(posedge clk);
    if (rst) begin
      known = 1'b1;
      ptr_m = 0;
      for (int u = 0; u < 3; u++) wait_m[u] = 0;
      for (int inst = 0; inst < 2; inst++) begin
        e_waddr[inst] = 5'd0; e_wdata[inst] = 32'd0; e_unit[inst] = 2'd0;
        e_wen[inst] = 1'b0; e_conf[inst] = 1'b0;
      end
    end else begin
      for (int inst = 0; inst < 2; inst++) begin
        int n, w;
        n = int'(v[inst][0]) + int'(v[inst][1]) + int'(v[inst][2]);
        w = w_last[inst];
        e_conf[inst] = (n >= 2);
        if (w >= 0) begin
          e_waddr[inst] = rd[inst][w];
          e_wdata[inst] = dt[inst][w];
          e_unit[inst]  = 2'(w);
          e_wen[inst]   = wr[inst][w] && (rd[inst][w] != 5'd0);
        end else begin
          e_wen[inst] = 1'b0;
        end
      end
      if (w_last[0] >= 0) ptr_m = (w_last[0] + 1) % 3;
      for (int u = 0; u < 3; u++)
        wait_m[u] = (v[1][u] && w_last[1] != u) ? ((wait_m[u] < 15) ? wait_m[u] + 1 : 15) : 0;
    end
    #1;
    if (rnd) begin
      for (int inst = 0; inst < 2; inst++)
        for (int u = 0; u < 3; u++)
          if (w_last[inst] == u || !v[inst][u]) begin
            if ($urandom_range(0, 1) == 1)
              set_req(inst, u, 1'b1, 5'($urandom_range(0, 31)), $urandom,
                      ($urandom_range(0, 3) != 0));
            else
              set_req(inst, u, 1'b0, 5'd0, 32'd0, 1'b0);
          end
    end
  endtask

  initial begin
    known = 1'b0;
    ptr_m = 0;
    for (int u = 0; u < 3; u++) wait_m[u] = 0;
    rst = 1'b1;
    set_both(0, 1'b1, 5'd3, 32'h0000_0A03, 1'b1);
    set_both(1, 1'b1, 5'd5, 32'h0000_0B05, 1'b1);
    set_both(2, 1'b1, 5'd7, 32'h0000_0C07, 1'b1);
    @(posedge clk); #1;
    step(1'b0); step(1'b0);
    rst = 1'b0;
    repeat (7) step(1'b0);
    clear_all(); step(1'b0);
    set_both(1, 1'b1, 5'd9, 32'h1234_5678, 1'b0); step(1'b0);
    clear_all(); step(1'b0);
    set_both(0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1); step(1'b0);
    clear_all(); step(1'b0);
    set_both(0, 1'b1, 5'd11, 32'h0000_1111, 1'b1);
    set_both(2, 1'b1, 5'd13, 32'h0000_1313, 1'b1);
    repeat (12) step(1'b0);
    clear_all(); step(1'b0);
    set_both(2, 1'b1, 5'd20, 32'h0000_2020, 1'b1); step(1'b0);
    rst = 1'b1; step(1'b0);
    step(1'b0);
    rst = 1'b0; clear_all(); step(1'b0);
    repeat (500) step(1'b1);
    clear_all(); step(1'b0); step(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
